// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Merges ALU and load (MEM) writeback requests onto the single register
//   file write port. Each source owns a one-entry holding buffer; one full
//   buffer is granted per cycle and its entry is registered onto
//   RegWrite/WR/WD at the following edge.
//
// Ports
//   clock, reset            : rising-edge clock, synchronous active-high reset
//   alu_valid/ready/addr/data : ALU writeback handshake
//   mem_valid/ready/addr/data : load writeback handshake
//   RegWrite, WR, WD        : registered register-file write port
//   pending                 : one bit per register, set while a buffered
//                             entry targets it (includes the grant cycle)
module regfile_write_arbiter #(
    parameter int DW = 16,
    parameter int AW = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [AW-1:0]     alu_addr,
    input  logic [DW-1:0]     alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [AW-1:0]     mem_addr,
    input  logic [DW-1:0]     mem_data,
    output logic              RegWrite,
    output logic [AW-1:0]     WR,
    output logic [DW-1:0]     WD,
    output logic [2**AW-1:0]  pending
);

    // holding buffers
    logic          a_vld_q, m_vld_q;
    logic [AW-1:0] a_addr_q, m_addr_q;
    logic [DW-1:0] a_data_q, m_data_q;

    // arbitration state: rr_q=0 favours ALU; mem_older_q=1 when the MEM
    // entry was loaded strictly before the ALU entry
    logic          rr_q, rr_d;
    logic          mem_older_q, mem_older_d;

    // registered write port
    logic          regwrite_q;
    logic [AW-1:0] wr_q;
    logic [DW-1:0] wd_q;

    logic          gnt_a, gnt_m;
    logic          a_load, m_load;

    // ---- stage 0: grant from buffer state only ----
    always_comb begin
        gnt_a = 1'b0;
        gnt_m = 1'b0;
        rr_d  = rr_q;
        if (a_vld_q && !m_vld_q) begin
            gnt_a = 1'b1;
        end else if (m_vld_q && !a_vld_q) begin
            gnt_m = 1'b1;
        end else if (a_vld_q && m_vld_q) begin
            if (a_addr_q == m_addr_q) begin
                // same destination: keep program order, rr untouched
                gnt_m = mem_older_q;
                gnt_a = !mem_older_q;
            end else begin
                gnt_m = rr_q;
                gnt_a = !rr_q;
                rr_d  = !rr_q;
            end
        end
    end

    // ready never looks at the port's own valid, only buffer/grant state
    assign alu_ready = !a_vld_q || gnt_a;
    assign mem_ready = !m_vld_q || gnt_m;
    assign a_load    = alu_valid && alu_ready;
    assign m_load    = mem_valid && mem_ready;

    // age only matters when both buffers are full afterwards; a buffer that
    // loads while the other one is held makes the other the older entry
    always_comb begin
        mem_older_d = mem_older_q;
        if (a_load && !m_load) begin
            mem_older_d = 1'b1;
        end else if (m_load) begin
            mem_older_d = 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < 2**AW; i++) begin
            pending[i] = (a_vld_q && (a_addr_q == AW'(i))) ||
                         (m_vld_q && (m_addr_q == AW'(i)));
        end
    end

    // ---- stage 1: buffer update and registered write port ----
    always_ff @(posedge clock) begin
        if (reset) begin
            a_vld_q     <= 1'b0;
            m_vld_q     <= 1'b0;
            rr_q        <= 1'b0;
            mem_older_q <= 1'b0;
            regwrite_q  <= 1'b0;
            wr_q        <= '0;
            wd_q        <= '0;
        end else begin
            a_vld_q     <= a_load || (a_vld_q && !gnt_a);
            m_vld_q     <= m_load || (m_vld_q && !gnt_m);
            rr_q        <= rr_d;
            mem_older_q <= mem_older_d;
            regwrite_q  <= gnt_a || gnt_m;
            if (gnt_a) begin
                wr_q <= a_addr_q;
                wd_q <= a_data_q;
            end else if (gnt_m) begin
                wr_q <= m_addr_q;
                wd_q <= m_data_q;
            end
        end
    end

    // buffer payload is qualified by the valid bits, so it needs no reset
    always_ff @(posedge clock) begin
        if (a_load) begin
            a_addr_q <= alu_addr;
            a_data_q <= alu_data;
        end
        if (m_load) begin
            m_addr_q <= mem_addr;
            m_data_q <= mem_data;
        end
    end

    assign RegWrite = regwrite_q;
    assign WR       = wr_q;
    assign WD       = wd_q;

endmodule
